// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM between the fetch and load/store ports.
// Optional MOC wait timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [31:0]       dm_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  input  logic              ram_moc,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACCESS, RELEASE, DONE, ERR} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  state_t      state;
  logic        gnt_dm;
  logic        last_grant_dm;
  logic        sgn;
  logic [1:0]  n_m1;
  logic [1:0]  idx;
  logic [31:0] wd;
  logic [31:0] asm_q;

  // Request decode for the port that would be granted this cycle.
  logic              pick_dm;
  logic              any_req;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic              req_bad;
  logic [1:0]        req_n_m1;
  logic [31:0]       req_wd;
  logic [31:0]       rd_ext;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick_dm  = dm_req && (!if_req || !last_grant_dm);
    any_req  = if_req || dm_req;
    req_size = pick_dm ? dm_size : 2'b10;
    req_addr = pick_dm ? dm_addr : if_addr;
    req_rw   = pick_dm && dm_rw;
    req_bad  = 1'b0;
    req_n_m1 = 2'd0;
    req_wd   = '0;
    case (req_size)
      2'b00: req_wd = {dm_wdata[7:0], 24'h0};
      2'b01: begin
        req_n_m1 = 2'd1;
        req_wd   = {dm_wdata[15:0], 16'h0};
        req_bad  = req_addr[0];
      end
      2'b10: begin
        req_n_m1 = 2'd3;
        req_wd   = dm_wdata;
        req_bad  = |req_addr[1:0];
      end
      default: req_bad = 1'b1;
    endcase
    if (!req_rw) req_wd = '0;
  end

  // The first byte read ends up most significant because each new byte shifts in at the bottom.
  always_comb begin
    case (n_m1)
      2'd0:    rd_ext = {{24{sgn & asm_q[7]}}, asm_q[7:0]};
      2'd1:    rd_ext = {{16{sgn & asm_q[15]}}, asm_q[15:0]};
      default: rd_ext = asm_q;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wcnt;
  logic              wait_expired;
  assign wait_expired = (wcnt == WAIT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state         <= IDLE;
      gnt_dm        <= 1'b0;
      last_grant_dm <= 1'b1;
      sgn           <= 1'b0;
      n_m1          <= 2'd0;
      idx           <= 2'd0;
      wd            <= '0;
      asm_q         <= '0;
      if_ack        <= 1'b0;
      if_err        <= 1'b0;
      if_rdata      <= '0;
      dm_ack        <= 1'b0;
      dm_err        <= 1'b0;
      dm_rdata      <= '0;
      ram_en        <= 1'b0;
      ram_rw        <= 1'b0;
      ram_addr      <= '0;
      ram_din       <= '0;
      busy          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wcnt          <= '0;
`endif
    end else begin
      // NOTE: pulse defaults come first; a later non-blocking assignment in this block overrides them.
      if_ack <= 1'b0;
      if_err <= 1'b0;
      dm_ack <= 1'b0;
      dm_err <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wcnt   <= '0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dm <= pick_dm;
            sgn    <= pick_dm && dm_signed;
            n_m1   <= req_n_m1;
            idx    <= 2'd0;
            asm_q  <= '0;
            busy   <= 1'b1;
            if (req_bad) begin
              state            <= ERR;
              {dm_ack, if_ack} <= pick_dm ? 2'b10 : 2'b01;
              {dm_err, if_err} <= pick_dm ? 2'b10 : 2'b01;
              last_grant_dm    <= pick_dm;
            end else begin
              state    <= ACCESS;
              ram_en   <= 1'b1;
              ram_rw   <= req_rw;
              ram_addr <= req_addr;
              ram_din  <= req_wd[31:24];
              wd       <= {req_wd[23:0], 8'h0};
            end
          end
        end

        ACCESS: begin
          if (ram_moc) begin
            if (!ram_rw) asm_q <= {asm_q[23:0], ram_dout};
            ram_en <= 1'b0;
            state  <= RELEASE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_expired) begin
            ram_en           <= 1'b0;
            state            <= ERR;
            {dm_ack, if_ack} <= gnt_dm ? 2'b10 : 2'b01;
            {dm_err, if_err} <= gnt_dm ? 2'b10 : 2'b01;
            last_grant_dm    <= gnt_dm;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end

        RELEASE: begin
          if (!ram_moc) begin
            if (idx == n_m1) begin
              state            <= DONE;
              {dm_ack, if_ack} <= gnt_dm ? 2'b10 : 2'b01;
              last_grant_dm    <= gnt_dm;
              if (!ram_rw) begin
                if (gnt_dm) dm_rdata <= rd_ext;
                else        if_rdata <= rd_ext;
              end
            end else begin
              idx      <= idx + 2'd1;
              ram_addr <= ram_addr + 1'b1;
              ram_din  <= wd[31:24];
              wd       <= {wd[23:0], 8'h0};
              ram_en   <= 1'b1;
              state    <= ACCESS;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_expired) begin
            state            <= ERR;
            {dm_ack, if_ack} <= gnt_dm ? 2'b10 : 2'b01;
            {dm_err, if_err} <= gnt_dm ? 2'b10 : 2'b01;
            last_grant_dm    <= gnt_dm;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end

        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          ram_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte RAM model that answers MOC one cycle after each enable edge.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        Clk = 1'b0;
  logic        Clear;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_rw;
  logic [1:0]  dm_size;
  logic        dm_signed;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic        dm_err;
  logic [31:0] dm_rdata;
  logic        ram_en;
  logic        ram_rw;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;
  logic        ram_moc = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(9), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Clear(Clear),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_signed(dm_signed), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_moc(ram_moc), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // RAM model: preloaded on the first Clear; a write commits on the edge where MOC is seen high.
  logic [7:0] mem [512];
  logic       mem_ready = 1'b0;
  logic       moc_stuck = 1'b0;
  logic       en_prev = 1'b0;
  int         en_rises = 0;
  int         overlaps = 0;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      5:  return 8'hF0;
      8:  return 8'h12;
      9:  return 8'h34;
      10: return 8'h56;
      11: return 8'h78;
      12: return 8'h80;
      13: return 8'h01;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (Clear && !mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end
    ram_moc <= ram_en && !moc_stuck;
    if (ram_en && !ram_moc) ram_dout <= mem[ram_addr];
    if (ram_en && ram_moc && ram_rw) mem[ram_addr] <= ram_din;
    en_prev <= ram_en;
    if (ram_en && !en_prev) en_rises <= en_rises + 1;
  end

  always @(negedge Clk) begin
    if (if_ack && dm_ack) overlaps <= overlaps + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits up to max negedges for an ack; lat counts posedges after the sampling edge.
  task automatic wait_ack(input int max, output logic got, output int lat, output int busy_low,
                          output logic [3:0] flags);
    got = 1'b0;
    lat = max;
    busy_low = 0;
    flags = 4'h0;
    for (int i = 1; i <= max; i++) begin
      @(negedge Clk);
      if (!busy) busy_low++;
      if (if_ack || dm_ack) begin
        got   = 1'b1;
        lat   = i - 1;
        flags = {if_ack, if_err, dm_ack, dm_err};
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input logic is_dm, input logic rw, input logic [1:0] size,
                     input logic sgn, input logic [8:0] addr, input logic [31:0] wdata,
                     output int lat, output logic [3:0] flags);
    logic got;
    int   bl;
    if (is_dm) begin
      dm_rw = rw; dm_size = size; dm_signed = sgn; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    wait_ack(40, got, lat, bl, flags);
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_held"}, bl, 0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    repeat (2) @(negedge Clk);
    Clear = 1'b0;
  endtask

  int         lat;
  int         bl;
  int         en_before;
  logic       got;
  logic [3:0] flags;

  initial begin
    Clear = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_rw = 1'b0; dm_size = 2'b00;
    dm_signed = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ctrl", {25'd0, busy, if_ack, if_err, dm_ack, dm_err, ram_en, ram_rw}, 32'd0);
    check("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {24'd0, ram_din}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    Clear = 1'b0;

    // Word fetch
    txn("fetch8", 1'b0, 1'b0, 2'b10, 1'b0, 9'd8, 32'd0, lat, flags);
    check("fetch8_lat", lat, 16);
    check("fetch8_flags", {28'd0, flags}, 32'h8);
    check("fetch8_rdata", if_rdata, 32'h12345678);

    // Byte loads, signed and unsigned
    txn("lb_s5", 1'b1, 1'b0, 2'b00, 1'b1, 9'd5, 32'd0, lat, flags);
    check("lb_s5_lat", lat, 4);
    check("lb_s5_flags", {28'd0, flags}, 32'h2);
    check("lb_s5_rdata", dm_rdata, 32'hFFFFFFF0);
    txn("lb_u5", 1'b1, 1'b0, 2'b00, 1'b0, 9'd5, 32'd0, lat, flags);
    check("lb_u5_rdata", dm_rdata, 32'h000000F0);

    // Signed halfword load of 0x8001
    txn("lh_s12", 1'b1, 1'b0, 2'b01, 1'b1, 9'd12, 32'd0, lat, flags);
    check("lh_s12_lat", lat, 8);
    check("lh_s12_rdata", dm_rdata, 32'hFFFF8001);

    // Halfword write; neighbours and dm_rdata untouched
    txn("sh6", 1'b1, 1'b1, 2'b01, 1'b0, 9'd6, 32'h1234BEEF, lat, flags);
    check("sh6_lat", lat, 8);
    check("sh6_flags", {28'd0, flags}, 32'h2);
    check("sh6_mem6", {24'd0, mem[6]}, 32'hBE);
    check("sh6_mem7", {24'd0, mem[7]}, 32'hEF);
    check("sh6_mem5", {24'd0, mem[5]}, 32'hF0);
    check("sh6_mem8", {24'd0, mem[8]}, 32'h12);
    check("sh6_rdata_held", dm_rdata, 32'hFFFF8001);

    // Errors: misaligned word, illegal size, odd halfword; no RAM enable
    en_before = en_rises;
    txn("sw2_mis", 1'b1, 1'b1, 2'b10, 1'b0, 9'd2, 32'hDEADBEEF, lat, flags);
    check("sw2_mis_lat", lat, 0);
    check("sw2_mis_flags", {28'd0, flags}, 32'h3);
    txn("size11", 1'b1, 1'b0, 2'b11, 1'b0, 9'd0, 32'd0, lat, flags);
    check("size11_flags", {28'd0, flags}, 32'h3);
    txn("lh7_mis", 1'b1, 1'b0, 2'b01, 1'b0, 9'd7, 32'd0, lat, flags);
    check("lh7_mis_flags", {28'd0, flags}, 32'h3);
    check("err_no_ram_en", en_rises, en_before);
    check("err_rdata_held", dm_rdata, 32'hFFFF8001);

    // Word write then read-back
    txn("sw16", 1'b1, 1'b1, 2'b10, 1'b0, 9'd16, 32'hCAFEF00D, lat, flags);
    check("sw16_lat", lat, 16);
    check("sw16_mem16", {24'd0, mem[16]}, 32'hCA);
    check("sw16_mem19", {24'd0, mem[19]}, 32'h0D);
    txn("lw16", 1'b1, 1'b0, 2'b10, 1'b0, 9'd16, 32'd0, lat, flags);
    check("lw16_rdata", dm_rdata, 32'hCAFEF00D);

    // Top of address space
    txn("lb_s510", 1'b1, 1'b0, 2'b00, 1'b1, 9'd510, 32'd0, lat, flags);
    check("lb_s510_rdata", dm_rdata, 32'hFFFFFFA4);
    txn("sb511", 1'b1, 1'b1, 2'b00, 1'b0, 9'd511, 32'h0000003C, lat, flags);
    check("sb511_mem511", {24'd0, mem[511]}, 32'h3C);
    check("sb511_mem510", {24'd0, mem[510]}, 32'hA4);

    // Contention from reset: IF, then DM, then IF
    pulse_clear();
    check("clr_dm_rdata", dm_rdata, 32'd0);
    if_addr = 9'd8; if_req = 1'b1;
    dm_rw = 1'b0; dm_size = 2'b10; dm_signed = 1'b0; dm_addr = 9'd16; dm_req = 1'b1;
    wait_ack(40, got, lat, bl, flags);
    check("tie1_flags", {28'd0, flags}, 32'h8);
    check("tie1_lat", lat, 16);
    check("tie1_busy", bl, 0);
    if_req = 1'b0;
    @(negedge Clk);
    if_req = 1'b1;
    wait_ack(40, got, lat, bl, flags);
    check("tie2_flags", {28'd0, flags}, 32'h2);
    check("tie2_lat", lat, 16);
    check("tie2_busy", bl, 0);
    check("tie2_rdata", dm_rdata, 32'hCAFEF00D);
    dm_req = 1'b0;
    @(negedge Clk);
    wait_ack(40, got, lat, bl, flags);
    check("tie3_flags", {28'd0, flags}, 32'h8);
    check("tie3_busy", bl, 0);
    check("tie3_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    @(negedge Clk);
    check("no_ack_overlap", overlaps, 0);

    // Clear during the third byte of a word write
    dm_rw = 1'b1; dm_size = 2'b10; dm_addr = 9'd20; dm_wdata = 32'h11223344; dm_req = 1'b1;
    repeat (9) @(negedge Clk);
    check("clr_mid_en", {31'd0, ram_en}, 32'd1);
    check("clr_mid_addr", {23'd0, ram_addr}, 32'd22);
    Clear = 1'b1;
    dm_req = 1'b0;
    @(negedge Clk);
    check("clr_mid_outs", {29'd0, ram_en, busy, dm_ack}, 32'd0);
    Clear = 1'b0;
    repeat (3) @(negedge Clk);
    check("clr_mem20", {24'd0, mem[20]}, 32'h11);
    check("clr_mem21", {24'd0, mem[21]}, 32'h22);
    check("clr_mem22", {24'd0, mem[22]}, 32'h4C);
    check("clr_mem23", {24'd0, mem[23]}, 32'h4D);

    // MOC never arrives
    moc_stuck = 1'b1;
    dm_rw = 1'b0; dm_size = 2'b00; dm_signed = 1'b0; dm_addr = 9'd5; dm_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_ack(60, got, lat, bl, flags);
    check("tmo_ack_seen", {31'd0, got}, 32'd1);
    check("tmo_lat", lat, TIMEOUT);
    check("tmo_flags", {28'd0, flags}, 32'h3);
    check("tmo_ram_en", {31'd0, ram_en}, 32'd0);
    dm_req = 1'b0;
    @(negedge Clk);
    moc_stuck = 1'b0;
    repeat (2) @(negedge Clk);
`else
    wait_ack(120, got, lat, bl, flags);
    check("hang_no_ack", {31'd0, got}, 32'd0);
    check("hang_busy", {31'd0, busy}, 32'd1);
    check("hang_busy_all", bl, 0);
    check("hang_ram_en", {31'd0, ram_en}, 32'd1);
    dm_req = 1'b0;
    pulse_clear();
    moc_stuck = 1'b0;
    repeat (2) @(negedge Clk);
    check("hang_cleared", {31'd0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the datapath's single byte-wide RAM between the instruction-fetch path and the load/store path. It arbitrates between the two requesters with round-robin priority. Each granted request becomes a sequence of byte accesses using the RAM's enable/MOC (memory-operation-complete) handshake. Read data is assembled big-endian into 32-bit words, with optional sign extension for byte and halfword loads.

## Interface
- ADDR_W, 9, RAM byte-address width
- TIMEOUT, 15, max cycles spent waiting on one MOC edge (used only with MEM_ARB_TIMEOUT_EN)

- Clk  in  1  clock, rising edge
- Clear  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address, word-aligned
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word, valid during if_ack, held until the next fetch completion
- if_err  out  1  pulses with if_ack on error
- dm_req  in  1  data request, held until dm_ack
- dm_rw  in  1  1 = write, 0 = read
- dm_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- dm_signed  in  1  sign-extend byte/halfword reads
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  write data; low 8/16/32 bits used
- dm_ack, dm_err, dm_rdata  out  1/1/32  same rules as the fetch port
- ram_en  out  1  memory function active
- ram_rw  out  1  1 = write
- ram_addr  out  ADDR_W  byte address
- ram_din  out  8  write byte
- ram_dout  in  8  read byte
- ram_moc  in  1  memory operation complete
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, RELEASE, DONE, ERR.
- **IDLE**
  - If exactly one req is high, grant it.
  - If both are high, grant the port not granted last. last_grant resets to DM, so IF wins the first tie.
  - Latch address, size (IF is always a word read), rw, wdata and signed. Set byte count N = 1/2/4 and idx = 0.
  - Illegal size, or misalignment (halfword with addr[0] set; word with addr[1:0] ≠ 0) → ERR, with no RAM activity.
  - Otherwise → ACCESS.
- **ACCESS**
  - Drive ram_en=1, ram_addr=base+idx, ram_rw.
  - ram_din = byte idx of the write data, big-endian: idx 0 is the most significant used byte.
  - On ram_moc=1: a read shifts ram_dout into the assembly register; then → RELEASE.
- **RELEASE**
  - ram_en=0. Wait for ram_moc=0.
  - Then, if idx = N−1 → DONE; otherwise idx+1 → ACCESS.
- **DONE**
  - Pulse the granted port's ack for one cycle and update last_grant; → IDLE.
  - Read data: the byte at the lowest address lands in the most significant used position. A byte or halfword is zero-extended, or sign-extended when signed=1.
  - A write leaves rdata unchanged.
- **ERR:** pulse ack and err together on the granted port for one cycle; → IDLE. last_grant is updated as in DONE.
- Aligned accesses never wrap the address. ram_addr is computed mod 2^ADDR_W.
- Requests are sampled only in IDLE. A req dropped mid-transaction does not abort it.
- A port may re-request in the cycle after its ack.
- Clear mid-transaction:
  - → IDLE; ram_en=0; last_grant=DM; no ack.
  - A partially written word stays partially written in RAM.

## Timing
- Reset: every output is 0, state IDLE.
- Memory model: raises ram_moc one cycle after ram_en rises and clears it one cycle after ram_en falls. Each byte then costs 4 cycles (ACCESS 2, RELEASE 2).
- Request sampled at IDLE edge E0 → ack is high during the cycle after edge E0+4N, i.e. 4 cycles for a byte and 16 for a word.
- Error: ack and err are high during the cycle after E0.
- Minimum spacing between back-to-back grants is one IDLE cycle.

## Configuration
- **MEM_ARB_TIMEOUT_EN defined:**
  - A wait counter runs in ACCESS (waiting for ram_moc=1) and RELEASE (waiting for ram_moc=0).
  - If the wait reaches TIMEOUT cycles: drop ram_en, go to ERR, pulse ack+err.
  - The counter clears on every state change.
- **Not defined:** the controller waits indefinitely; err flags only illegal or misaligned requests.

## Test plan
- Word fetch: Mem[8..11] = 8'h12, 34, 56, 78; IF at 8 → if_rdata = 32'h12345678, if_ack 16 cycles after the sample, if_err = 0.
- Signed byte load: Mem[5] = 8'hF0, signed=1 → dm_rdata = 32'hFFFFFFF0; with signed=0 → 32'h000000F0.
- Halfword write: 16'hBEEF to 6 → Mem[6] = 8'hBE, Mem[7] = 8'hEF, no other bytes touched; then a word write to 2 → dm_ack+dm_err after 1 cycle and ram_en never rises.
- Contention: both requesting from reset → IF served first, then DM, then IF; no grant overlaps, and busy stays high throughout.
- Clear asserted in the 3rd byte of a word write → next cycle ram_en = 0, busy = 0, no ack; Mem holds 2 new bytes.
- With MEM_ARB_TIMEOUT_EN: ram_moc held at 0 → ack+err after TIMEOUT cycles in ACCESS and ram_en drops; without the macro, busy stays high for 100+ cycles.
